// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: the requester drives start/a/b,
// the subtractor returns busy/done and the held diff/borrow.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor bit per clock with a registered borrow.
// The result and final borrow are held until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_bflop;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             w_load;
  logic             w_last;
  logic [1:0]       w_fs;
  logic             w_d;
  logic             w_bo;

  // Full subtractor: returns {difference, borrow_out}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic dd;
    logic bo;
    dd = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
    return {dd, bo};
  endfunction

  assign w_fs = full_sub(r_sa[0], r_sb[0], r_bflop);
  assign w_d  = w_fs[1];
  assign w_bo = w_fs[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture and per-bit shift; diff/borrow only update on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sd     <= '0;
      r_bflop  <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_load) begin
      r_sa    <= bus.a;
      r_sb    <= bus.b;
      r_sd    <= '0;
      r_bflop <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_sd    <= {w_d, r_sd[WIDTH-1:1]};
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_bflop <= w_bo;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff   <= {w_d, r_sd[WIDTH-1:1]};
        r_borrow <= w_bo;
      end
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;

endmodule
